// File: rtl/ahb_lite_arbiter_2m_pkg.sv
// Shared AHB-Lite types and constants for the two-master arbiter.
package ahb_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_B = 3'b000;
  localparam logic [2:0] HSIZE_H = 3'b001;
  localparam logic [2:0] HSIZE_W = 3'b010;

  // Address-phase owner / grant encoding
  typedef enum logic {
    MST0 = 1'b0,
    MST1 = 1'b1
  } mst_e;

  // One complete AHB-Lite address phase
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } ahb_addr_t;

endpackage

// File: rtl/ahb_lite_arbiter_2m_if.sv
// AHB-Lite bus bundle; master drives address/write data, slave drives response.
interface ahb_lite_arbiter_2m_if;
  import ahb_lite_pkg::*;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock, hwdata,
    output hrdata, hready, hresp
  );

endinterface

// File: rtl/ahb_lite_arbiter_2m_input_stage.sv
// Per-master input stage: one-deep address-phase buffer, effective-request
// mux and the master-facing HREADY/HRESP.
module ahb_arb_input_stage
  import ahb_lite_pkg::*;
#(
  parameter logic MST_IDX = 1'b0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  ahb_addr_t live_i,
  input  logic      fwd_i,
  input  logic      dvalid_i,
  input  logic      downer_i,
  input  logic      s_hready_i,
  input  logic      s_hresp_i,
  output ahb_addr_t eff_c_o,
  output logic      hready_c_o,
  output logic      hresp_c_o
);

  ahb_addr_t pend_q, pend_d;
  logic      pend_valid_q, pend_valid_d;
  logic      own_dphase;
  logic      capture;

  assign own_dphase = dvalid_i && (downer_i == MST_IDX);
  assign eff_c_o    = pend_valid_q ? pend_q : live_i;
  assign hresp_c_o  = own_dphase ? s_hresp_i : 1'b0;

  // Stall the master only while its buffered address waits for the bus
  always_comb begin
    hready_c_o = 1'b1;
    if (own_dphase) begin
      hready_c_o = s_hready_i;
    end else if (pend_valid_q) begin
      hready_c_o = 1'b0;
    end
  end

  // A live request is buffered when it is not passing straight through;
  // with a full buffer it can only enter on the edge the buffer drains.
  assign capture = hready_c_o && live_i.trans[1] && (pend_valid_q ? fwd_i : !fwd_i);

  // Buffer next-state
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (pend_valid_q && fwd_i) begin
      pend_valid_d = 1'b0;
    end
    if (capture) begin
      pend_d       = live_i;
      pend_valid_d = 1'b1;
    end
  end

  // Buffer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

endmodule

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter in front of a single slave path. Grant moves
// only between complete bursts/locked sequences.
module ahb_lite_arbiter_2m
  import ahb_lite_pkg::*;
#(
  parameter int unsigned RR      = 1,
  parameter int unsigned DEF_MST = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  ahb_lite_arbiter_2m_if.slave   m0,
  ahb_lite_arbiter_2m_if.slave   m1,
  ahb_lite_arbiter_2m_if.master  s,
  output logic                   S_HMASTER
);

  localparam mst_e DEF_GNT = (DEF_MST != 0) ? MST1 : MST0;

  mst_e      grant_q, grant_d;
  logic      dvalid_q, dvalid_d;
  logic      downer_q, downer_d;
  ahb_addr_t live0, live1, eff0, eff1, eff_g;
  logic      fwd0, fwd1;
  logic      req0, req1, hold;
  logic      m0_hready_c, m1_hready_c, m0_hresp_c, m1_hresp_c;

  assign live0 = '{addr: m0.haddr, trans: m0.htrans, write: m0.hwrite, size: m0.hsize,
                   burst: m0.hburst, prot: m0.hprot, lock: m0.hmastlock};
  assign live1 = '{addr: m1.haddr, trans: m1.htrans, write: m1.hwrite, size: m1.hsize,
                   burst: m1.hburst, prot: m1.hprot, lock: m1.hmastlock};

  ahb_arb_input_stage #(.MST_IDX(1'b0)) u_stage0 (
    .clk_i(HCLK), .rst_i(HRESET), .live_i(live0), .fwd_i(fwd0),
    .dvalid_i(dvalid_q), .downer_i(downer_q), .s_hready_i(s.hready), .s_hresp_i(s.hresp),
    .eff_c_o(eff0), .hready_c_o(m0_hready_c), .hresp_c_o(m0_hresp_c)
  );

  ahb_arb_input_stage #(.MST_IDX(1'b1)) u_stage1 (
    .clk_i(HCLK), .rst_i(HRESET), .live_i(live1), .fwd_i(fwd1),
    .dvalid_i(dvalid_q), .downer_i(downer_q), .s_hready_i(s.hready), .s_hresp_i(s.hresp),
    .eff_c_o(eff1), .hready_c_o(m1_hready_c), .hresp_c_o(m1_hresp_c)
  );

  assign eff_g = (grant_q == MST1) ? eff1 : eff0;
  assign fwd0  = (grant_q == MST0) && s.hready;
  assign fwd1  = (grant_q == MST1) && s.hready;
  assign req0  = (eff0.trans == HTRANS_NONSEQ);
  assign req1  = (eff1.trans == HTRANS_NONSEQ);

  // Owner keeps the bus through locks and multi-beat bursts
  assign hold = eff_g.lock
             || (eff_g.trans == HTRANS_SEQ)
             || (eff_g.trans == HTRANS_BUSY)
             || ((eff_g.trans == HTRANS_NONSEQ) && (eff_g.burst != HBURST_SINGLE));

  // Grant next-state: round-robin or fixed priority, parks when idle
  always_comb begin
    grant_d = grant_q;
    if (s.hready && !hold) begin
      if (RR != 0) begin
        if (grant_q == MST0) begin
          if (req1) grant_d = MST1;
        end else begin
          if (req0) grant_d = MST0;
        end
      end else begin
        if (req0) begin
          grant_d = MST0;
        end else if (req1) begin
          grant_d = MST1;
        end
      end
    end
  end

  // Data-phase tracking follows the address phase accepted by the slave
  always_comb begin
    dvalid_d = dvalid_q;
    downer_d = downer_q;
    if (s.hready) begin
      dvalid_d = eff_g.trans[1];
      downer_d = 1'(grant_q);
    end
  end

  // Grant and data-phase registers
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      grant_q  <= DEF_GNT;
      dvalid_q <= 1'b0;
      downer_q <= 1'b0;
    end else begin
      grant_q  <= grant_d;
      dvalid_q <= dvalid_d;
      downer_q <= downer_d;
    end
  end

  assign s.haddr     = eff_g.addr;
  assign s.htrans    = HRESET ? HTRANS_IDLE : eff_g.trans;
  assign s.hwrite    = eff_g.write;
  assign s.hsize     = eff_g.size;
  assign s.hburst    = eff_g.burst;
  assign s.hprot     = eff_g.prot;
  assign s.hmastlock = eff_g.lock;
  assign s.hwdata    = downer_q ? m1.hwdata : m0.hwdata;
  assign S_HMASTER   = 1'(grant_q);

  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;
  assign m0.hready = m0_hready_c;
  assign m1.hready = m1_hready_c;
  assign m0.hresp  = m0_hresp_c;
  assign m1.hresp  = m1_hresp_c;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench: a round-robin arbiter plus a fixed-priority twin fed the
// same master/slave stimulus.
module tb_ahb_lite_arbiter_2m;
  import ahb_lite_pkg::*;

  logic HCLK;
  logic HRESET;
  logic hmst_a, hmst_b;
  int   total = 0;
  int   bad   = 0;
  logic prev_mst = 1'b0;

  ahb_lite_arbiter_2m_if m0_a ();
  ahb_lite_arbiter_2m_if m1_a ();
  ahb_lite_arbiter_2m_if s_a ();
  ahb_lite_arbiter_2m_if m0_b ();
  ahb_lite_arbiter_2m_if m1_b ();
  ahb_lite_arbiter_2m_if s_b ();

  ahb_lite_arbiter_2m #(.RR(1), .DEF_MST(0)) u_dut_rr (
    .HCLK(HCLK), .HRESET(HRESET), .m0(m0_a), .m1(m1_a), .s(s_a), .S_HMASTER(hmst_a)
  );

  ahb_lite_arbiter_2m #(.RR(0), .DEF_MST(0)) u_dut_fp (
    .HCLK(HCLK), .HRESET(HRESET), .m0(m0_b), .m1(m1_b), .s(s_b), .S_HMASTER(hmst_b)
  );

  assign m0_b.haddr = m0_a.haddr;   assign m1_b.haddr = m1_a.haddr;
  assign m0_b.htrans = m0_a.htrans; assign m1_b.htrans = m1_a.htrans;
  assign m0_b.hwrite = m0_a.hwrite; assign m1_b.hwrite = m1_a.hwrite;
  assign m0_b.hsize = m0_a.hsize;   assign m1_b.hsize = m1_a.hsize;
  assign m0_b.hburst = m0_a.hburst; assign m1_b.hburst = m1_a.hburst;
  assign m0_b.hprot = m0_a.hprot;   assign m1_b.hprot = m1_a.hprot;
  assign m0_b.hmastlock = m0_a.hmastlock;
  assign m1_b.hmastlock = m1_a.hmastlock;
  assign m0_b.hwdata = m0_a.hwdata; assign m1_b.hwdata = m1_a.hwdata;
  assign s_b.hrdata = s_a.hrdata;
  assign s_b.hready = s_a.hready;
  assign s_b.hresp  = s_a.hresp;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Grant must never switch onto a SEQ/BUSY address phase
  always @(negedge HCLK) begin
    if (!HRESET && (hmst_a != prev_mst)) begin
      total++;
      if (s_a.htrans == HTRANS_SEQ || s_a.htrans == HTRANS_BUSY) begin
        bad++;
        $display("FAIL switch_onto_seq got htrans=%b on new owner %0d", s_a.htrans, hmst_a);
      end
    end
    prev_mst = hmst_a;
  end

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic [2:0] b, input logic [31:0] wd);
    if (m == 0) begin
      m0_a.htrans = tr; m0_a.haddr = a; m0_a.hwrite = w; m0_a.hburst = b; m0_a.hwdata = wd;
    end else begin
      m1_a.htrans = tr; m1_a.haddr = a; m1_a.hwrite = w; m1_a.hburst = b; m1_a.hwdata = wd;
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
    drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
    s_a.hready = 1'b1; s_a.hresp = 1'b0;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    m0_a.hsize = HSIZE_W; m0_a.hprot = 4'b0011; m0_a.hmastlock = 1'b0;
    m1_a.hsize = HSIZE_W; m1_a.hprot = 4'b0011; m1_a.hmastlock = 1'b0;
    s_a.hready = 1'b1; s_a.hresp = 1'b0; s_a.hrdata = 32'h0;
    drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
    repeat (2) @(posedge HCLK);
    #1 drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE, 32'h11110001);
    @(negedge HCLK);
    total++; if (s_a.htrans !== HTRANS_IDLE) begin bad++; $display("FAIL rst_htrans got=%b exp=00", s_a.htrans); end
    total++; if (hmst_a !== 1'b0) begin bad++; $display("FAIL rst_hmaster got=%b exp=0", hmst_a); end
    total++; if (m0_a.hready !== 1'b1 || m1_a.hready !== 1'b1) begin bad++; $display("FAIL rst_hready got=%b%b exp=11", m0_a.hready, m1_a.hready); end
    total++; if (m0_a.hresp !== 1'b0 || m1_a.hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%b%b exp=00", m0_a.hresp, m1_a.hresp); end
    total++; if (hmst_b !== 1'b0) begin bad++; $display("FAIL rst_hmaster_fp got=%b exp=0", hmst_b); end
    @(posedge HCLK); #1 HRESET = 1'b0;
  endtask

  task automatic test_single_m0();
    for (int i = 0; i < 4; i++) begin
      s_a.hrdata = 32'hD00D0000 + 32'(i);
      @(negedge HCLK);
      total++; if (s_a.htrans !== HTRANS_NONSEQ || s_a.haddr !== 32'h100) begin bad++; $display("FAIL t1_fwd c%0d got=%b/%h exp=10/100", i, s_a.htrans, s_a.haddr); end
      total++; if (hmst_a !== 1'b0 || m0_a.hready !== 1'b1) begin bad++; $display("FAIL t1_grant c%0d got mst=%b rdy=%b exp 0/1", i, hmst_a, m0_a.hready); end
      total++; if (m0_a.hrdata !== 32'hD00D0000 + 32'(i) || m1_a.hrdata !== 32'hD00D0000 + 32'(i)) begin bad++; $display("FAIL t1_hrdata c%0d got=%h/%h", i, m0_a.hrdata, m1_a.hrdata); end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_rr_capture();
    do_reset();
    drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE, 32'h11110002);
    @(posedge HCLK); #1;
    drv(1, HTRANS_NONSEQ, 32'h200, 1'b1, HBURST_SINGLE, 32'h0);
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b0 || m1_a.hready !== 1'b1) begin bad++; $display("FAIL t2_c0 got mst=%b rdy1=%b exp 0/1", hmst_a, m1_a.hready); end
    @(posedge HCLK); #1 drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'hCAFE0002);
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b1 || s_a.haddr !== 32'h200 || s_a.hwrite !== 1'b1 || s_a.htrans !== HTRANS_NONSEQ) begin bad++; $display("FAIL t2_c1_fwd got mst=%b addr=%h w=%b tr=%b", hmst_a, s_a.haddr, s_a.hwrite, s_a.htrans); end
    total++; if (m1_a.hready !== 1'b0) begin bad++; $display("FAIL t2_c1_rdy1 got=%b exp=0", m1_a.hready); end
    total++; if (s_a.hwdata !== 32'h11110002) begin bad++; $display("FAIL t2_c1_wdata got=%h exp=11110002", s_a.hwdata); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b0 || s_a.haddr !== 32'h100) begin bad++; $display("FAIL t2_c2_back got mst=%b addr=%h", hmst_a, s_a.haddr); end
    total++; if (m1_a.hready !== 1'b1 || m0_a.hready !== 1'b0) begin bad++; $display("FAIL t2_c2_rdy got=%b%b exp m1=1 m0=0", m1_a.hready, m0_a.hready); end
    total++; if (s_a.hwdata !== 32'hCAFE0002) begin bad++; $display("FAIL t2_c2_wdata got=%h exp=cafe0002", s_a.hwdata); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b0 || m0_a.hready !== 1'b1) begin bad++; $display("FAIL t2_c3 got mst=%b rdy0=%b exp 0/1", hmst_a, m0_a.hready); end
  endtask

  task automatic test_both_request();
    do_reset();
    drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE, 32'h0);
    drv(1, HTRANS_NONSEQ, 32'h200, 1'b1, HBURST_SINGLE, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      total++; if (hmst_a !== 1'(i % 2)) begin bad++; $display("FAIL t3_rr_mst c%0d got=%b exp=%0d", i, hmst_a, i % 2); end
      total++; if (s_a.haddr !== ((i % 2 == 1) ? 32'h200 : 32'h100)) begin bad++; $display("FAIL t3_rr_addr c%0d got=%h", i, s_a.haddr); end
      total++; if (hmst_b !== 1'b0 || s_b.haddr !== 32'h100) begin bad++; $display("FAIL t3_fp_mst c%0d got=%b/%h exp 0/100", i, hmst_b, s_b.haddr); end
      total++; if (m1_b.hready !== (i == 0)) begin bad++; $display("FAIL t3_fp_starve c%0d got=%b", i, m1_b.hready); end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_burst();
    logic        exp_mst  [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
    logic [1:0]  exp_tr   [8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b10, 2'b00, 2'b00};
    logic        exp_rdy1 [8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    logic [31:0] exp_addr [8] = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h0, 32'h200, 32'h0, 32'h0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drv(0, HTRANS_NONSEQ, 32'h300, 1'b0, 3'b011, 32'h0);
      else if (i < 4) drv(0, HTRANS_SEQ, 32'h300 + 32'(4 * i), 1'b0, 3'b011, 32'h0);
      else drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
      if (i == 0) drv(1, HTRANS_NONSEQ, 32'h200, 1'b1, HBURST_SINGLE, 32'h0);
      else drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
      @(negedge HCLK);
      total++; if (hmst_a !== exp_mst[i] || s_a.htrans !== exp_tr[i]) begin bad++; $display("FAIL t4_beat c%0d got mst=%b tr=%b exp %b/%b", i, hmst_a, s_a.htrans, exp_mst[i], exp_tr[i]); end
      total++; if (m1_a.hready !== exp_rdy1[i]) begin bad++; $display("FAIL t4_wait1 c%0d got=%b exp=%b", i, m1_a.hready, exp_rdy1[i]); end
      if (i < 6 && i != 4) begin
        total++; if (s_a.haddr !== exp_addr[i]) begin bad++; $display("FAIL t4_addr c%0d got=%h exp=%h", i, s_a.haddr, exp_addr[i]); end
      end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_stall();
    logic        exp_mst  [8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    logic        exp_rdy1 [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    logic        exp_rdy0 [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
    logic        exp_rsp1 [8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      if (j == 0) drv(1, HTRANS_NONSEQ, 32'h200, 1'b1, HBURST_SINGLE, 32'h0);
      else drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'hBEEF0005);
      if (j < 2) drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
      else drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE, 32'h11110005);
      s_a.hready = !(j >= 2 && j <= 4);
      s_a.hresp  = (j == 4 || j == 5);
      @(negedge HCLK);
      total++; if (hmst_a !== exp_mst[j]) begin bad++; $display("FAIL t5_mst c%0d got=%b exp=%b", j, hmst_a, exp_mst[j]); end
      total++; if (m1_a.hready !== exp_rdy1[j] || m0_a.hready !== exp_rdy0[j]) begin bad++; $display("FAIL t5_rdy c%0d got m1=%b m0=%b exp %b/%b", j, m1_a.hready, m0_a.hready, exp_rdy1[j], exp_rdy0[j]); end
      total++; if (m1_a.hresp !== exp_rsp1[j] || m0_a.hresp !== 1'b0) begin bad++; $display("FAIL t5_resp c%0d got m1=%b m0=%b exp %b/0", j, m1_a.hresp, m0_a.hresp, exp_rsp1[j]); end
      if (j >= 2) begin
        total++; if (s_a.hwdata !== ((j == 7) ? 32'h11110005 : 32'hBEEF0005)) begin bad++; $display("FAIL t5_wdata c%0d got=%h", j, s_a.hwdata); end
      end
      if (j == 6) begin
        total++; if (s_a.htrans !== HTRANS_NONSEQ || s_a.haddr !== 32'h100) begin bad++; $display("FAIL t5_m0_fwd got tr=%b addr=%h exp 10/100", s_a.htrans, s_a.haddr); end
      end
      @(posedge HCLK); #1;
    end
    s_a.hready = 1'b1; s_a.hresp = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drv(0, HTRANS_NONSEQ, 32'h100, 1'b0, HBURST_SINGLE, 32'h0);
    drv(1, HTRANS_NONSEQ, 32'h400, 1'b1, 3'b011, 32'h0);
    @(posedge HCLK); #1 drv(1, HTRANS_SEQ, 32'h404, 1'b1, 3'b011, 32'h0);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b1 || s_a.htrans !== HTRANS_SEQ || s_a.haddr !== 32'h404) begin bad++; $display("FAIL t6_pre got mst=%b tr=%b addr=%h", hmst_a, s_a.htrans, s_a.haddr); end
    total++; if (m0_a.hready !== 1'b0) begin bad++; $display("FAIL t6_pre_pend got rdy0=%b exp=0", m0_a.hready); end
    #2 HRESET = 1'b1;
    #1;
    total++; if (s_a.htrans !== HTRANS_IDLE || hmst_a !== 1'b0) begin bad++; $display("FAIL t6_async got tr=%b mst=%b exp 00/0", s_a.htrans, hmst_a); end
    total++; if (m0_a.hready !== 1'b1 || m1_a.hready !== 1'b1) begin bad++; $display("FAIL t6_async_rdy got=%b%b exp=11", m0_a.hready, m1_a.hready); end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    drv(0, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
    drv(1, HTRANS_IDLE, 32'h0, 1'b0, HBURST_SINGLE, 32'h0);
    @(negedge HCLK);
    total++; if (hmst_a !== 1'b0 || s_a.htrans !== HTRANS_IDLE) begin bad++; $display("FAIL t6_no_replay got mst=%b tr=%b exp 0/00", hmst_a, s_a.htrans); end
    @(posedge HCLK); #1 drv(0, HTRANS_NONSEQ, 32'h500, 1'b0, HBURST_SINGLE, 32'h0);
    @(negedge HCLK);
    total++; if (s_a.htrans !== HTRANS_NONSEQ || s_a.haddr !== 32'h500 || m0_a.hready !== 1'b1) begin bad++; $display("FAIL t6_after got tr=%b addr=%h rdy0=%b", s_a.htrans, s_a.haddr, m0_a.hready); end
    @(posedge HCLK); #1;
  endtask

  initial begin
    test_reset();
    test_single_m0();
    test_rr_capture();
    test_both_request();
    test_burst();
    test_stall();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
